// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
//
// Shared definitions for the data-memory arbiter: default data/address
// widths (same values as the core's width macros) and the arbiter FSM
// state encoding.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  // Default widths, matching the rest of the core
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_ACC = 2'd1,
    RESP    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port synchronous data memory between the EX-stage
// load/store port and an external debug/loader master. The CPU normally
// wins. The debug master waits behind CPU traffic for at most MAX_WAIT
// cycles, after which it is forced in for one cycle and the pipeline is
// stalled if the CPU wanted the memory in that same cycle.
//
// Ports:
//   CLK, RST_N            clock (rising edge), async active-low reset
//   CPU_REQ/WE/ADDR/WDATA EX-stage load/store request
//   CPU_RDATA             load data, the cycle after a granted CPU read
//   CPU_STALL             hold PC, IF/ID and ID/EX this cycle
//   DBG_REQ/WE/ADDR/WDATA debug request, held until DBG_ACK
//   DBG_ACK               one-cycle completion pulse
//   DBG_RDATA             last debug read data
//   MEM_ADDR/WDATA/WE     to data_memory
//   MEM_RDATA             from data_memory, one-cycle read latency
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_STALL,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_full;
  logic              dbg_eligible;
  logic              dbg_grant;
  logic              dbg_we_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [DATA_W-1:0] dbg_wdata_q;

  // The request still visible during the ack cycle belongs to the
  // transaction that is just finishing, so it must not start a new one.
  assign dbg_eligible = DBG_REQ & ~DBG_ACK;
  assign wait_full    = (wait_cnt >= WAIT_W'(MAX_WAIT));
  assign dbg_grant    = (state_q == IDLE) & dbg_eligible & (~CPU_REQ | wait_full);

  // Load data comes straight from the memory; only meaningful after a
  // granted CPU read.
  assign CPU_RDATA = MEM_RDATA;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a granted debug access always takes exactly
  // one access cycle and one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dbg_grant) state_d = DBG_ACC;
      DBG_ACC: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the memory belongs to the CPU except during DBG_ACC,
  // when the captured debug access is presented and any CPU access that
  // cycle is stalled so the pipeline re-presents it next cycle.
  always_comb begin
    MEM_ADDR  = CPU_ADDR;
    MEM_WDATA = CPU_WDATA;
    MEM_WE    = CPU_REQ & CPU_WE;
    CPU_STALL = 1'b0;
    if (state_q == DBG_ACC) begin
      MEM_ADDR  = dbg_addr_q;
      MEM_WDATA = dbg_wdata_q;
      MEM_WE    = dbg_we_q;
      CPU_STALL = CPU_REQ;
    end
  end

  // Starvation counter: counts cycles a debug request is eligible but
  // blocked by the CPU, saturating at MAX_WAIT so the forced grant
  // condition stays true until the grant happens.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (dbg_grant) begin
      wait_cnt <= '0;
    end else if ((state_q == IDLE) && dbg_eligible && CPU_REQ && !wait_full) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Debug request capture, so the master's inputs need not be stable
  // during the access cycle itself.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
    end else if (dbg_grant) begin
      dbg_we_q    <= DBG_WE;
      dbg_addr_q  <= DBG_ADDR;
      dbg_wdata_q <= DBG_WDATA;
    end
  end

  // Debug completion: in RESP the memory output holds the debug read
  // result; the ack is registered so it appears the cycle after RESP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DBG_ACK   <= 1'b0;
      DBG_RDATA <= '0;
    end else begin
      DBG_ACK <= (state_q == RESP);
      if ((state_q == RESP) && !dbg_we_q) begin
        DBG_RDATA <= MEM_RDATA;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between the pipeline's EX-stage load/store and an external debug/loader master.
CPU has priority. The debug master uses a req/ack handshake, and a starvation counter bounds its wait.
When debug owns the memory while the CPU also requests it, the block stalls the pipeline (PC, IF/ID, ID/EX hold) for that cycle.
Sits between the cpu top level and data_memory. Its CPU_STALL is ORed with the hazard unit's stall.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, memory address width
MAX_WAIT, 8, blocked debug cycles before a forced grant (>=1)
WAIT_W, 4, wait-counter width; must hold MAX_WAIT

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
CPU_REQ  in  1  EX stage performs a load/store this cycle
CPU_WE  in  1  1 = store
CPU_ADDR  in  ADDR_W  CPU address (ALU result)
CPU_WDATA  in  DATA_W  store data
CPU_RDATA  out  DATA_W  load data, valid the cycle after a granted CPU read
CPU_STALL  out  1  hold the pipeline this cycle
DBG_REQ  in  1  debug request, held until DBG_ACK
DBG_WE  in  1  1 = write
DBG_ADDR  in  ADDR_W  debug address
DBG_WDATA  in  DATA_W  debug write data
DBG_ACK  out  1  one-cycle completion pulse
DBG_RDATA  out  DATA_W  debug read data, valid from DBG_ACK until the next debug read completes
MEM_ADDR  out  ADDR_W  to data_memory
MEM_WDATA  out  DATA_W  to data_memory
MEM_WE  out  1  to data_memory
MEM_RDATA  in  DATA_W  from data_memory; 1-cycle read latency

Behaviour:
- Reset (asynchronous, any state, including mid-access): state=IDLE, wait_cnt=0, DBG_ACK=0, DBG_RDATA=0, captured debug registers=0, CPU_STALL=0.
- FSM has three states: IDLE, DBG_ACC, RESP.
- IDLE:
  - Memory is driven by the CPU port. MEM_WE=CPU_REQ&CPU_WE. CPU_STALL=0.
  - Debug is eligible when DBG_REQ=1 and DBG_ACK=0. The ack-cycle request is ignored.
  - Grant when eligible and (CPU_REQ=0 or wait_cnt>=MAX_WAIT). On grant: capture DBG_WE/ADDR/WDATA, clear wait_cnt, go to DBG_ACC.
  - Eligible but blocked by CPU_REQ: wait_cnt increments, saturating at MAX_WAIT.
- DBG_ACC (exactly 1 cycle):
  - Memory is driven from the captured registers.
  - CPU_STALL=CPU_REQ; the stalled CPU access is re-presented next cycle.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - Memory is driven by the CPU port again, with no stall.
  - MEM_RDATA carries the debug read data. On a debug read, register it into DBG_RDATA; on a debug write, DBG_RDATA is unchanged.
  - DBG_ACK is registered to 1 at the end of RESP, so it is high in the following cycle.
  - Next state: IDLE.
- Latency: debug capture at cycle N, memory access N+1, DBG_ACK high at N+3.
- Worst-case debug wait behind continuous CPU traffic: MAX_WAIT cycles.
- CPU_RDATA=MEM_RDATA (combinational). It is meaningful only after a granted CPU read; no CPU read is ever granted in DBG_ACC.
- Debug has at most one outstanding request; a new request is accepted no earlier than the cycle after the ack.
- No address translation, width conversion or bounds check: addresses pass through unchanged.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults (matching the existing width macros) and the state encodings IDLE=2'd0, DBG_ACC=2'd1, RESP=2'd2.
- Single module, no sub-modules. The saturating wait counter is inline.

Test Plan:
1. Debug read with CPU idle: preload mem[0x10]=0xBEEF, DBG_REQ read 0x10 at cycle 0. DBG_ACK pulses at cycle 3 with DBG_RDATA=0xBEEF. CPU_STALL stays 0.
2. Debug write, then CPU load: debug writes 0x1234 to 0x20. After the ack, CPU load 0x20 gives CPU_RDATA=0x1234 the next cycle.
3. Starvation: CPU_REQ held high continuously, DBG_REQ asserted. Capture occurs after exactly MAX_WAIT=8 blocked cycles. CPU_STALL=1 for exactly one cycle (DBG_ACC). The CPU store issued in that cycle lands in memory one cycle later, with the correct value.
4. Back-to-back debug: DBG_REQ held through the ack. The second capture happens the cycle after the ack, never during it. Two distinct acks occur 4 cycles apart.
5. Reset mid-access: assert RST_N=0 during DBG_ACC. DBG_ACK and CPU_STALL go to 0 immediately and no ack follows. After release, a fresh debug read completes normally.
